edgcol_reg_reader: RTL and testbench

EDGCOL_REG_READER -- requirements
Module: edgcol_reg_reader

---
 rtl/edgcol_reg_reader.sv | 178 +++++++++++++++++
 tb/tb_edgcol_reg_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/edgcol_reg_reader.sv
// Snapshots the six-entry edge-collision register file on start and streams the
// unmasked words out over a valid/ready interface, lowest index first.
module edgcol_reg_reader #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rdData0,
    input  logic [REG_WIDTH-1:0] rdData1,
    input  logic [REG_WIDTH-1:0] rdData2,
    input  logic [REG_WIDTH-1:0] rdData3,
    input  logic [REG_WIDTH-1:0] rdData4,
    input  logic [REG_WIDTH-1:0] rdData5,
    input  logic                 start,
    input  logic [5:0]           skipMask,
    input  logic                 outReady,
    output logic                 outValid,
    output logic [REG_WIDTH-1:0] outData,
    output logic [2:0]           outIdx,
    output logic                 outLast,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [5:0]           mask_q, mask_d;
    logic [REG_WIDTH-1:0] snap_q [6];
    logic [REG_WIDTH-1:0] snap_d [6];
    logic [REG_WIDTH-1:0] rd_s   [6];
    logic [3:0]           first_s;
    logic [3:0]           next_s;
    logic [3:0]           after_s;

    logic                 out_valid_q, out_valid_d;
    logic [REG_WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]           out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Returns {found, index} of the lowest unmasked entry at or above 'from'.
    function automatic logic [3:0] find_next(input logic [5:0] mask, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 5; i >= 0; i--) begin
            if ((4'(i) >= from) && !mask[i]) begin
                r = {1'b1, 3'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [REG_WIDTH-1:0] pick(input logic [REG_WIDTH-1:0] s [6], input logic [2:0] i);
        logic [REG_WIDTH-1:0] v;
        case (i)
            3'd0:    v = s[0];
            3'd1:    v = s[1];
            3'd2:    v = s[2];
            3'd3:    v = s[3];
            3'd4:    v = s[4];
            3'd5:    v = s[5];
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        rd_s[0] = rdData0;
        rd_s[1] = rdData1;
        rd_s[2] = rdData2;
        rd_s[3] = rdData3;
        rd_s[4] = rdData4;
        rd_s[5] = rdData5;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            mask_q      <= 6'd0;
            for (int i = 0; i < 6; i++) snap_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            for (int i = 0; i < 6; i++) snap_q[i] <= snap_d[i];
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // In SEND the registered outValid is 1, so outReady alone marks a handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        for (int i = 0; i < 6; i++) snap_d[i] = snap_q[i];
        first_s = find_next(skipMask, 4'd0);
        next_s  = find_next(mask_q, {1'b0, idx_q} + 4'd1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 6; i++) snap_d[i] = rd_s[i];
                    mask_d = skipMask;
                    if (first_s[3]) begin
                        state_d = SEND;
                        idx_d   = first_s[2:0];
                    end else begin
                        state_d = DONE;
                        idx_d   = 3'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (outReady) begin
                    if (next_s[3]) begin
                        idx_d = next_s[2:0];
                    end else begin
                        state_d = DONE;
                        idx_d   = 3'd0;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        after_s     = find_next(mask_d, {1'b0, idx_d} + 4'd1);
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_idx_d   = 3'd0;
        out_last_d  = 1'b0;
        if (state_d == SEND) begin
            out_valid_d = 1'b1;
            out_data_d  = pick(snap_d, idx_d);
            out_idx_d   = idx_d;
            out_last_d  = !after_s[3];
        end else begin
            out_valid_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outIdx   = out_idx_q;
    assign outLast  = out_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_edgcol_reg_reader.sv
// Directed bench for edgcol_reg_reader: inputs change and outputs are sampled
// on the falling clock edge.
module tb_edgcol_reg_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd0, rd1, rd2, rd3, rd4, rd5;
    logic        start = 1'b0;
    logic [5:0]  skipMask = 6'd0;
    logic        outReady = 1'b1;
    logic        outValid;
    logic [31:0] outData;
    logic [2:0]  outIdx;
    logic        outLast;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    edgcol_reg_reader #(.REG_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rdData0(rd0), .rdData1(rd1), .rdData2(rd2),
        .rdData3(rd3), .rdData4(rd4), .rdData5(rd5),
        .start(start), .skipMask(skipMask), .outReady(outReady),
        .outValid(outValid), .outData(outData), .outIdx(outIdx),
        .outLast(outLast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] base);
        rd0 = base;         rd1 = base + 32'd1; rd2 = base + 32'd2;
        rd3 = base + 32'd3; rd4 = base + 32'd4; rd5 = base + 32'd5;
    endtask

    task automatic expect_word(input string tag, input logic [2:0] idx,
                               input logic [31:0] data, input logic last);
        chk({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        chk({tag, "_idx"},   {29'd0, outIdx}, {29'd0, idx});
        chk({tag, "_data"},  outData, data);
        chk({tag, "_last"},  {31'd0, outLast}, {31'd0, last});
        chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
    endtask

    task automatic expect_idle_outs(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_valid"}, {31'd0, outValid}, 32'd0);
        chk({tag, "_data"},  outData, 32'd0);
        chk({tag, "_idx"},   {29'd0, outIdx}, 32'd0);
        chk({tag, "_last"},  {31'd0, outLast}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, {31'd0, exp_busy});
        chk({tag, "_done"},  {31'd0, done}, {31'd0, exp_done});
    endtask

    initial begin
        set_data(32'd10);
        #2;
        expect_idle_outs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full stream, one word per cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_word("full", 3'(i), 32'd10 + 32'(i), (i == 5));
            @(negedge clk);
        end
        expect_idle_outs("full_done", 1'b1, 1'b1);
        @(negedge clk);
        expect_idle_outs("full_idle", 1'b0, 1'b0);

        // Masked stream: only idx 0, 2, 4.
        skipMask = 6'b101010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        skipMask = 6'd0;
        expect_word("mask0", 3'd0, 32'd10, 1'b0);
        @(negedge clk);
        expect_word("mask2", 3'd2, 32'd12, 1'b0);
        @(negedge clk);
        expect_word("mask4", 3'd4, 32'd14, 1'b1);
        @(negedge clk);
        expect_idle_outs("mask_done", 1'b1, 1'b1);
        @(negedge clk);
        expect_idle_outs("mask_idle", 1'b0, 1'b0);

        // All masked: straight to DONE.
        skipMask = 6'b111111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        skipMask = 6'd0;
        expect_idle_outs("allmask_done", 1'b1, 1'b1);
        @(negedge clk);
        expect_idle_outs("allmask_idle", 1'b0, 1'b0);

        // Backpressure at idx 2 for three cycles.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_word("bp0", 3'd0, 32'd10, 1'b0);
        @(negedge clk);
        expect_word("bp1", 3'd1, 32'd11, 1'b0);
        @(negedge clk);
        expect_word("bp2a", 3'd2, 32'd12, 1'b0);
        outReady = 1'b0;
        @(negedge clk);
        expect_word("bp2b", 3'd2, 32'd12, 1'b0);
        @(negedge clk);
        expect_word("bp2c", 3'd2, 32'd12, 1'b0);
        @(negedge clk);
        expect_word("bp2d", 3'd2, 32'd12, 1'b0);
        outReady = 1'b1;
        @(negedge clk);
        expect_word("bp3", 3'd3, 32'd13, 1'b0);
        @(negedge clk);
        expect_word("bp4", 3'd4, 32'd14, 1'b0);
        @(negedge clk);
        expect_word("bp5", 3'd5, 32'd15, 1'b1);
        @(negedge clk);
        expect_idle_outs("bp_done", 1'b1, 1'b1);
        @(negedge clk);

        // Snapshot isolation and start ignored during SEND.
        set_data(32'h0000_0100);
        start = 1'b1;
        @(negedge clk);
        rd0 = 32'hFFFF_FFFF; rd1 = 32'hFFFF_FFFF; rd2 = 32'hFFFF_FFFF;
        rd3 = 32'hFFFF_FFFF; rd4 = 32'hFFFF_FFFF; rd5 = 32'hFFFF_FFFF;
        skipMask = 6'b111111;
        expect_word("iso0", 3'd0, 32'h100, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            expect_word("iso", 3'(i), 32'h100 + 32'(i), (i == 5));
            @(negedge clk);
        end
        expect_idle_outs("iso_done", 1'b1, 1'b1);
        @(negedge clk);
        expect_idle_outs("iso_idle", 1'b0, 1'b0);
        skipMask = 6'd0;
        set_data(32'd10);

        // Reset mid-stream at idx 3.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        expect_word("pre_rst3", 3'd3, 32'd13, 1'b0);
        rst = 1'b1;
        #1;
        expect_idle_outs("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        expect_idle_outs("in_rst", 1'b0, 1'b0);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_word("post_rst", 3'(i), 32'd10 + 32'(i), (i == 5));
            @(negedge clk);
        end
        expect_idle_outs("post_rst_done", 1'b1, 1'b1);
        @(negedge clk);
        expect_idle_outs("post_rst_idle", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
